// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared state encoding and counter widths for the AES clock-gate controller
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_GATED     = 2'd0,
        ST_WAKE      = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_IDLE_WAIT = 2'd3
    } ctrl_state_t;

    localparam int WAKE_CYCLES_MAX = 15;
    localparam int IDLE_CYCLES_MAX = 255;

    // Counters are sized for the largest legal parameter value, not the chosen one,
    // so the register map is identical across instances.
    localparam int WAKE_CNT_W  = $clog2(WAKE_CYCLES_MAX);
    localparam int IDLE_CNT_W  = $clog2(IDLE_CYCLES_MAX);
    localparam int GATED_CNT_W = 32;

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// rtl/clock_gate_ctrl_if.sv - job handshake between upstream and the gated AES core
interface clock_gate_ctrl_if;

    logic req_valid;
    logic req_ready;

    modport master (
        output req_valid,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        output req_ready
    );

endinterface

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - wake/idle FSM driving the enable of an external clock-gating cell
module clock_gate_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    clock_gate_ctrl_if.slave       req,
    input  logic                   core_busy,
    input  logic                   force_on,
    output logic                   gate_en,
    output logic                   clk_on,
    output logic [GATED_CNT_W-1:0] gated_cycles
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LOAD = IDLE_CNT_W'(IDLE_CYCLES - 1);

    ctrl_state_t            state_q;
    ctrl_state_t            state_d;
    logic [WAKE_CNT_W-1:0]  wake_cnt_q;
    logic [WAKE_CNT_W-1:0]  wake_cnt_d;
    logic [IDLE_CNT_W-1:0]  idle_cnt_q;
    logic [IDLE_CNT_W-1:0]  idle_cnt_d;
    logic [GATED_CNT_W-1:0] gated_cnt_q;
    logic                   activity;

    // Anything that means the core must keep its clock while it is already running.
    assign activity = req.req_valid | core_busy | force_on;

    // State and counter registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_GATED;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Next-state logic; WAKE always runs to completion so the gated clock settles.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_GATED: begin
                if (req.req_valid || force_on) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!activity) begin
                    state_d    = ST_IDLE_WAIT;
                    idle_cnt_d = IDLE_LOAD;
                end
            end
            ST_IDLE_WAIT: begin
                // Activity is checked first so it beats an expiring idle count.
                if (activity) begin
                    state_d = ST_ACTIVE;
                end else if (idle_cnt_q == '0) begin
                    state_d = ST_GATED;
                end else begin
                    idle_cnt_d = idle_cnt_q - IDLE_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_GATED;
            end
        endcase
    end

    // Saturating count of cycles spent with the clock gated.
    always_ff @(posedge clk) begin
        if (rst) begin
            gated_cnt_q <= '0;
        end else if ((state_q == ST_GATED) && (gated_cnt_q != '1)) begin
            gated_cnt_q <= gated_cnt_q + GATED_CNT_W'(1);
        end
    end

    // Outputs decode only the state register, so gate_en moves only on clk rising edges.
    assign gate_en       = (state_q != ST_GATED);
    assign req.req_ready = (state_q == ST_ACTIVE) || (state_q == ST_IDLE_WAIT);
    assign clk_on        = (state_q == ST_ACTIVE) || (state_q == ST_IDLE_WAIT);
    assign gated_cycles  = gated_cnt_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - directed self-checking bench for clock_gate_ctrl
module tb_clock_gate_ctrl;
    import aes_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        core_busy;
    logic        force_on;
    logic        gate_en;
    logic        clk_on;
    logic [31:0] gated_cycles;
    int          checks;
    int          errors;

    clock_gate_ctrl_if bus ();

    clock_gate_ctrl #(
        .WAKE_CYCLES (2),
        .IDLE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus),
        .core_busy    (core_busy),
        .force_on     (force_on),
        .gate_en      (gate_en),
        .clk_on       (clk_on),
        .gated_cycles (gated_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req_valid = 1'b0; core_busy = 1'b0; force_on = 1'b0;
        repeat (3) tick();
        checks++;
        if (gate_en !== 1'b0 || bus.req_ready !== 1'b0 || clk_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gate_en=%b req_ready=%b clk_on=%b expected 0 0 0", gate_en, bus.req_ready, clk_on);
        end
        checks++;
        if (gated_cycles !== 32'd0 || dut.state_q !== ST_GATED) begin
            errors++;
            $display("FAIL reset_state: gated_cycles=%0d state=%0d expected 0 %0d", gated_cycles, dut.state_q, ST_GATED);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gated_cycles !== 32'd1) begin
            errors++;
            $display("FAIL reset_first_count: gated_cycles=%0d expected 1", gated_cycles);
        end
    endtask

    // Enters with state GATED and gated_cycles=1.
    task automatic test_wake_latency();
        bus.req_valid = 1'b1;
        tick();
        checks++;
        if (gate_en !== 1'b1 || bus.req_ready !== 1'b0 || dut.wake_cnt_q !== 4'd1) begin
            errors++;
            $display("FAIL wake_first: gate_en=%b req_ready=%b wake_cnt=%0d expected 1 0 1", gate_en, bus.req_ready, dut.wake_cnt_q);
        end
        tick();
        checks++;
        if (gate_en !== 1'b1 || bus.req_ready !== 1'b0 || dut.wake_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL wake_second: gate_en=%b req_ready=%b wake_cnt=%0d expected 1 0 0", gate_en, bus.req_ready, dut.wake_cnt_q);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || clk_on !== 1'b1 || dut.state_q !== ST_ACTIVE) begin
            errors++;
            $display("FAIL wake_ready: req_ready=%b clk_on=%b state=%0d expected 1 1 %0d", bus.req_ready, clk_on, dut.state_q, ST_ACTIVE);
        end
        checks++;
        if (gated_cycles !== 32'd2) begin
            errors++;
            $display("FAIL wake_gated_count: gated_cycles=%0d expected 2", gated_cycles);
        end
    endtask

    // Enters in ACTIVE with gated_cycles=2.
    task automatic test_idle_gate();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (dut.state_q !== ST_IDLE_WAIT || dut.idle_cnt_q !== 8'd3 || gate_en !== 1'b1) begin
            errors++;
            $display("FAIL idle_enter: state=%0d idle_cnt=%0d gate_en=%b expected %0d 3 1", dut.state_q, dut.idle_cnt_q, gate_en, ST_IDLE_WAIT);
        end
        repeat (3) tick();
        checks++;
        if (dut.state_q !== ST_IDLE_WAIT || dut.idle_cnt_q !== 8'd0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_last: state=%0d idle_cnt=%0d req_ready=%b expected %0d 0 1", dut.state_q, dut.idle_cnt_q, bus.req_ready, ST_IDLE_WAIT);
        end
        tick();
        checks++;
        if (dut.state_q !== ST_GATED || gate_en !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_gated: state=%0d gate_en=%b req_ready=%b expected %0d 0 0", dut.state_q, gate_en, bus.req_ready, ST_GATED);
        end
        tick();
        checks++;
        if (gated_cycles !== 32'd3) begin
            errors++;
            $display("FAIL idle_gated_count: gated_cycles=%0d expected 3", gated_cycles);
        end
    endtask

    // Enters GATED; exercises the activity-vs-expiry race and core_busy hold.
    task automatic test_idle_race();
        int drops;
        drops = 0;
        bus.req_valid = 1'b1;
        repeat (3) tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (gate_en !== 1'b1) drops++;
        end
        checks++;
        if (dut.state_q !== ST_IDLE_WAIT || dut.idle_cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL race_setup: state=%0d idle_cnt=%0d expected %0d 0", dut.state_q, dut.idle_cnt_q, ST_IDLE_WAIT);
        end
        bus.req_valid = 1'b1;
        #1;
        checks++;
        if ((bus.req_valid & bus.req_ready) !== 1'b1) begin
            errors++;
            $display("FAIL race_accept: transfer=%b expected 1", bus.req_valid & bus.req_ready);
        end
        tick();
        if (gate_en !== 1'b1) drops++;
        checks++;
        if (dut.state_q !== ST_ACTIVE || drops != 0) begin
            errors++;
            $display("FAIL race_active: state=%0d gate_en_drops=%0d expected %0d 0", dut.state_q, drops, ST_ACTIVE);
        end
        bus.req_valid = 1'b0;
        core_busy = 1'b1;
        repeat (6) tick();
        checks++;
        if (dut.state_q !== ST_ACTIVE) begin
            errors++;
            $display("FAIL busy_hold: state=%0d expected %0d", dut.state_q, ST_ACTIVE);
        end
        core_busy = 1'b0;
        repeat (5) tick();
        checks++;
        if (dut.state_q !== ST_GATED || gated_cycles !== 32'd4) begin
            errors++;
            $display("FAIL busy_release: state=%0d gated_cycles=%0d expected %0d 4", dut.state_q, gated_cycles, ST_GATED);
        end
    endtask

    // Enters GATED.
    task automatic test_force_on();
        int low_seen;
        int budget;
        low_seen = 0;
        force_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gate_en !== 1'b1) low_seen++;
        end
        checks++;
        if (low_seen != 0 || dut.state_q !== ST_ACTIVE) begin
            errors++;
            $display("FAIL force_hold: low_cycles=%0d state=%0d expected 0 %0d", low_seen, dut.state_q, ST_ACTIVE);
        end
        force_on = 1'b0;
        repeat (4) tick();
        checks++;
        if (gate_en !== 1'b1) begin
            errors++;
            $display("FAIL force_release_early: gate_en=%b expected 1", gate_en);
        end
        tick();
        checks++;
        if (gate_en !== 1'b0) begin
            errors++;
            $display("FAIL force_release_gate: gate_en=%b expected 0", gate_en);
        end
        budget = 0;
        while (dut.state_q !== ST_GATED && budget < 50) begin
            tick();
            budget++;
        end
        checks++;
        if (dut.state_q !== ST_GATED) begin
            errors++;
            $display("FAIL force_settle_timeout: state=%0d expected %0d", dut.state_q, ST_GATED);
        end
    endtask

    // Enters GATED.
    task automatic test_reset_mid_wake();
        bus.req_valid = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== ST_WAKE || dut.wake_cnt_q !== 4'd1) begin
            errors++;
            $display("FAIL rst_wake_setup: state=%0d wake_cnt=%0d expected %0d 1", dut.state_q, dut.wake_cnt_q, ST_WAKE);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== ST_GATED || gate_en !== 1'b0 || bus.req_ready !== 1'b0 || gated_cycles !== 32'd0 || dut.wake_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL rst_wake: state=%0d gate_en=%b req_ready=%b gated_cycles=%0d wake_cnt=%0d expected %0d 0 0 0 0",
                     dut.state_q, gate_en, bus.req_ready, gated_cycles, dut.wake_cnt_q, ST_GATED);
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    // Enters GATED; backdoor-loads the counter near its ceiling.
    task automatic test_saturate();
        dut.gated_cnt_q = 32'hFFFF_FFFE;
        tick();
        checks++;
        if (gated_cycles !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_reach: gated_cycles=%0h expected ffffffff", gated_cycles);
        end
        repeat (2) tick();
        checks++;
        if (gated_cycles !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_hold: gated_cycles=%0h expected ffffffff", gated_cycles);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wake_latency();
        test_idle_gate();
        test_idle_race();
        test_force_on();
        test_reset_mid_wake();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
